signed_multiplier_top: RTL and testbench

Three independent 4×4 two's-complement multiplier lanes (sv, v and vhd), each with its own operands and its own 8-bit signed product. All three lanes must produce identical, bit-exact results. Products are purely combinational. A clocked self-check block compares each lane against an internal reference product and records mismatches. The block is a leaf: a structural equivalence vehicle for the three lane implementations, driven directly by stimulus.

---
 rtl/signed_multiplier_top_if.sv | 25 ++
 rtl/signed_multiplier_top.sv | 85 ++++++++
 tb/tb_signed_multiplier_top.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/signed_multiplier_top_if.sv
// Operand/product bundle for the three 4x4 signed multiplier lanes and their self-check status.
// The master side drives the operands; the slave side (the multiplier) returns the products and status.
interface signed_multiplier_top_if;
  logic [3:0] a_sv;
  logic [3:0] b_sv;
  logic [7:0] y_sv;
  logic [3:0] a_v;
  logic [3:0] b_v;
  logic [7:0] y_v;
  logic [3:0] a_vhd;
  logic [3:0] b_vhd;
  logic [7:0] y_vhd;
  logic [2:0] mismatch;
  logic [7:0] err_count;

  modport master (
    output a_sv, b_sv, a_v, b_v, a_vhd, b_vhd,
    input  y_sv, y_v, y_vhd, mismatch, err_count
  );

  modport slave (
    input  a_sv, b_sv, a_v, b_v, a_vhd, b_vhd,
    output y_sv, y_v, y_vhd, mismatch, err_count
  );
endinterface

// File: rtl/signed_multiplier_top.sv
// Three independently built 4x4 two's-complement multipliers (behavioural, shift-and-add, Baugh-Wooley).
// Optional clocked self-check against a reference multiply is compiled in with MULT_SELFCHECK_EN.
module signed_multiplier_top (
  input  logic                         clk,
  input  logic                         reset,
  signed_multiplier_top_if.slave       bus
);

  // Lane sv: behavioural signed multiply on sign-extended operands
  assign bus.y_sv = 8'($signed(bus.a_sv)) * 8'($signed(bus.b_sv));

  // Lane v: four sign-extended partial products; the b[3] row carries weight -8 so it is subtracted
  logic [7:0] a_v_ext;
  logic [7:0] v_pp [4];

  assign a_v_ext = {{4{bus.a_v[3]}}, bus.a_v};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_v_pp
      assign v_pp[gi] = bus.b_v[gi] ? (a_v_ext << gi) : 8'h00;
    end
  endgenerate

  assign bus.y_v = v_pp[0] + v_pp[1] + v_pp[2] - v_pp[3];

  // Lane vhd: Baugh-Wooley array; cross terms with exactly one sign bit are inverted,
  // and 2^4 + 2^7 restores the offset those inversions introduce
  logic [3:0] vhd_pp  [4];
  logic [7:0] vhd_row [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_vhd_row
      for (genvar gj = 0; gj < 4; gj++) begin : g_vhd_col
        if ((gi == 3) != (gj == 3)) begin : g_inv
          assign vhd_pp[gi][gj] = ~(bus.a_vhd[gi] & bus.b_vhd[gj]);
        end else begin : g_pos
          assign vhd_pp[gi][gj] = bus.a_vhd[gi] & bus.b_vhd[gj];
        end
      end
      assign vhd_row[gi] = {4'b0000, vhd_pp[gi]} << gi;
    end
  endgenerate

  assign bus.y_vhd = vhd_row[0] + vhd_row[1] + vhd_row[2] + vhd_row[3] + 8'h90;

`ifdef MULT_SELFCHECK_EN
  function automatic logic [7:0] ref_mul(input logic [3:0] a, input logic [3:0] b);
    logic signed [7:0] a_ext;
    logic signed [7:0] b_ext;
    a_ext = 8'($signed(a));
    b_ext = 8'($signed(b));
    return a_ext * b_ext;
  endfunction

  logic [2:0] mismatch_next;
  logic [2:0] mismatch_reg;
  logic [7:0] err_count_reg;

  // Compare against the products as seen on the bus so a fault on any lane output is observed
  assign mismatch_next[0] = bus.y_sv  != ref_mul(bus.a_sv,  bus.b_sv);
  assign mismatch_next[1] = bus.y_v   != ref_mul(bus.a_v,   bus.b_v);
  assign mismatch_next[2] = bus.y_vhd != ref_mul(bus.a_vhd, bus.b_vhd);

  always_ff @(posedge clk) begin
    if (!reset) begin
      mismatch_reg  <= 3'b000;
      err_count_reg <= 8'h00;
    end else begin
      mismatch_reg <= mismatch_next;
      if ((mismatch_reg != 3'b000) && (err_count_reg != 8'hFF)) begin
        err_count_reg <= err_count_reg + 8'h01;
      end
    end
  end

  assign bus.mismatch  = mismatch_reg;
  assign bus.err_count = err_count_reg;
`else
  logic unused_ok;
  assign unused_ok     = clk ^ reset;
  assign bus.mismatch  = 3'b000;
  assign bus.err_count = 8'h00;
`endif

endmodule

// File: tb/tb_signed_multiplier_top.sv
// Scoreboard bench for signed_multiplier_top: sweep, corners, lane independence, reset and self-check.
module tb_signed_multiplier_top;
  logic clk;
  logic reset;
  int   total;
  int   bad;

  typedef struct {
    string      tag;
    logic [7:0] y_sv;
    logic [7:0] y_v;
    logic [7:0] y_vhd;
  } exp_t;

  exp_t sb_q[$];

  signed_multiplier_top_if bus ();

  signed_multiplier_top dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%02h exp=%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_mul(input logic [3:0] a, input logic [3:0] b);
    int sa;
    int sb;
    int p;
    sa = a[3] ? int'(a) - 16 : int'(a);
    sb = b[3] ? int'(b) - 16 : int'(b);
    p  = sa * sb;
    return p[7:0];
  endfunction

  // Drive on the rising edge, push the expectation, then pop and compare on the falling edge
  task automatic apply(input string tag,
                       input logic [3:0] asv, input logic [3:0] bsv,
                       input logic [3:0] av,  input logic [3:0] bv,
                       input logic [3:0] avhd, input logic [3:0] bvhd);
    exp_t e;
    @(posedge clk);
    bus.a_sv = asv;  bus.b_sv = bsv;
    bus.a_v  = av;   bus.b_v  = bv;
    bus.a_vhd = avhd; bus.b_vhd = bvhd;
    e.tag   = tag;
    e.y_sv  = model_mul(asv, bsv);
    e.y_v   = model_mul(av, bv);
    e.y_vhd = model_mul(avhd, bvhd);
    sb_q.push_back(e);
    @(negedge clk);
    e = sb_q.pop_front();
    chk({e.tag, ".sv"},  bus.y_sv,  e.y_sv);
    chk({e.tag, ".v"},   bus.y_v,   e.y_v);
    chk({e.tag, ".vhd"}, bus.y_vhd, e.y_vhd);
    chk({e.tag, ".mm"},  {5'b0, bus.mismatch}, 8'h00);
    chk({e.tag, ".ec"},  bus.err_count, 8'h00);
  endtask

  initial begin
    logic [7:0] idx;
    logic [7:0] jdx;
    logic [7:0] kdx;
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.a_sv = 4'h5; bus.b_sv = 4'h3;
    bus.a_v  = 4'h0; bus.b_v  = 4'h0;
    bus.a_vhd = 4'h0; bus.b_vhd = 4'h0;

    // Reset held for two cycles: status cleared, product still live
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst.mm", {5'b0, bus.mismatch}, 8'h00);
      chk("rst.ec", bus.err_count, 8'h00);
      chk("rst.y_sv", bus.y_sv, 8'h0F);
    end
    @(negedge clk);
    reset = 1'b1;

    // Corners, identical on all lanes
    apply("c_88", 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8);
    chk("c_88.lit", bus.y_vhd, 8'h40);
    apply("c_87", 4'h8, 4'h7, 4'h8, 4'h7, 4'h8, 4'h7);
    chk("c_87.lit", bus.y_v, 8'hC8);
    apply("c_ff", 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF);
    chk("c_ff.lit", bus.y_sv, 8'h01);
    apply("c_30", 4'h3, 4'h0, 4'h3, 4'h0, 4'h3, 4'h0);
    chk("c_30.lit", bus.y_vhd, 8'h00);
    apply("c_77", 4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 4'h7);
    chk("c_77.lit", bus.y_v, 8'h31);

    // Lane independence
    apply("indep", 4'h7, 4'h7, 4'h8, 4'h1, 4'hF, 4'h2);
    chk("indep.sv",  bus.y_sv,  8'h31);
    chk("indep.v",   bus.y_v,   8'hF8);
    chk("indep.vhd", bus.y_vhd, 8'hFE);

    // Exhaustive sweep; each lane walks all 256 pairs in a different order
    for (int i = 0; i < 256; i++) begin
      idx = 8'(i);
      jdx = 8'(i * 7 + 3);
      kdx = 8'(255 - i);
      apply($sformatf("sw%0d", i), idx[7:4], idx[3:0], jdx[7:4], jdx[3:0], kdx[7:4], kdx[3:0]);
    end

`ifdef MULT_SELFCHECK_EN
    // One-cycle fault on lane sv
    @(negedge clk);
    force bus.y_sv = ~bus.y_sv;
    @(negedge clk);
    release bus.y_sv;
    chk("f1.mm", {5'b0, bus.mismatch}, 8'h01);
    chk("f1.ec0", bus.err_count, 8'h00);
    @(negedge clk);
    chk("f1.mm_clr", {5'b0, bus.mismatch}, 8'h00);
    chk("f1.ec1", bus.err_count, 8'h01);
    @(negedge clk);
    chk("f1.ec_hold", bus.err_count, 8'h01);

    // One-cycle fault on lane vhd
    force bus.y_vhd = ~bus.y_vhd;
    @(negedge clk);
    release bus.y_vhd;
    chk("f2.mm", {5'b0, bus.mismatch}, 8'h04);
    @(negedge clk);
    chk("f2.ec", bus.err_count, 8'h02);

    // Long fault on lane v drives err_count into saturation
    force bus.y_v = ~bus.y_v;
    for (int c = 0; c < 300; c++) @(negedge clk);
    chk("sat.mm", {5'b0, bus.mismatch}, 8'h02);
    release bus.y_v;
    @(negedge clk);
    @(negedge clk);
    chk("sat.ec", bus.err_count, 8'hFF);
    chk("sat.mm_clr", {5'b0, bus.mismatch}, 8'h00);

    // Reset mid-operation clears status while products stay valid
    reset = 1'b0;
    @(negedge clk);
    chk("rst2.ec", bus.err_count, 8'h00);
    chk("rst2.y_sv", bus.y_sv, model_mul(bus.a_sv, bus.b_sv));
    reset = 1'b1;
`endif

    chk("sb.empty", 8'(sb_q.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
